// File: rtl/axi4_if.sv
// AXI4 bus bundle shared by the arbiter's upstream and downstream ports.
// The master modport drives requests; the slave modport drives responses.
interface axi4_if #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned ID_WIDTH   = 4
);
  localparam int unsigned StrbWidth = DATA_WIDTH / 8;

  logic [ID_WIDTH-1:0]   awid;
  logic [ADDR_WIDTH-1:0] awaddr;
  logic [7:0]            awlen;
  logic [2:0]            awsize;
  logic [1:0]            awburst;
  logic                  awlock;
  logic [3:0]            awcache;
  logic [2:0]            awprot;
  logic [3:0]            awqos;
  logic                  awvalid;
  logic                  awready;

  logic [DATA_WIDTH-1:0] wdata;
  logic [StrbWidth-1:0]  wstrb;
  logic                  wlast;
  logic                  wvalid;
  logic                  wready;

  logic [ID_WIDTH-1:0]   bid;
  logic [1:0]            bresp;
  logic                  bvalid;
  logic                  bready;

  logic [ID_WIDTH-1:0]   arid;
  logic [ADDR_WIDTH-1:0] araddr;
  logic [7:0]            arlen;
  logic [2:0]            arsize;
  logic [1:0]            arburst;
  logic                  arlock;
  logic [3:0]            arcache;
  logic [2:0]            arprot;
  logic [3:0]            arqos;
  logic                  arvalid;
  logic                  arready;

  logic [ID_WIDTH-1:0]   rid;
  logic [DATA_WIDTH-1:0] rdata;
  logic [1:0]            rresp;
  logic                  rlast;
  logic                  rvalid;
  logic                  rready;

  modport master (
    output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awqos, awvalid,
    input  awready,
    output wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bid, bresp, bvalid,
    output bready,
    output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arqos, arvalid,
    input  arready,
    input  rid, rdata, rresp, rlast, rvalid,
    output rready
  );

  modport slave (
    input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awqos, awvalid,
    output awready,
    input  wdata, wstrb, wlast, wvalid,
    output wready,
    output bid, bresp, bvalid,
    input  bready,
    input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arqos, arvalid,
    output arready,
    output rid, rdata, rresp, rlast, rvalid,
    input  rready
  );
endinterface

// File: rtl/axi4_arbiter_2x1.sv
// Two-master to one-slave AXI4 arbiter: round-robin AW/AR grant, W steered in AW order,
// B/R routed back by the extra source bit prepended to the downstream ID.
module axi4_arbiter_2x1 #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned ID_WIDTH   = 4,
  parameter int unsigned WQ_DEPTH   = 4
) (
  input  logic   ACLK,
  input  logic   ARESETn,
  axi4_if.slave  m0,
  axi4_if.slave  m1,
  axi4_if.master s
);

  localparam int unsigned PtrW      = $clog2(WQ_DEPTH);
  localparam int unsigned StrbWidth = DATA_WIDTH / 8;
  localparam logic [PtrW:0] PtrOne  = (PtrW + 1)'(1);

  typedef enum logic {StFree, StHold} arb_state_e;

  // ---------------------------------------------------------------------------
  // AW arbitration
  // ---------------------------------------------------------------------------
  arb_state_e aw_st_q, aw_st_d;
  logic aw_hold_q, aw_hold_d;
  logic aw_last_q, aw_last_d;
  logic aw_gnt, aw_req, aw_valid, aw_hs;
  logic [ADDR_WIDTH-1:0] aw_addr;

  // W-order queue state, declared early because it gates AW.
  logic [WQ_DEPTH-1:0] wq_mem_q;
  logic [PtrW:0] wq_wptr_q, wq_rptr_q;
  logic wq_empty, wq_full, wq_head, wq_pop;

  always_comb begin
    aw_gnt = 1'b0;
    if (aw_st_q == StHold) begin
      aw_gnt = aw_hold_q;
    end else if (m0.awvalid && m1.awvalid) begin
      aw_gnt = ~aw_last_q;
    end else begin
      aw_gnt = m1.awvalid;
    end
  end

  always_comb begin
    aw_req     = aw_gnt ? m1.awvalid : m0.awvalid;
    aw_valid   = ARESETn && aw_req && !wq_full;
    aw_hs      = aw_valid && s.awready;
    s.awvalid  = aw_valid;
    m0.awready = ARESETn && !wq_full && !aw_gnt && s.awready;
    m1.awready = ARESETn && !wq_full && aw_gnt && s.awready;
  end

  always_comb begin
    s.awid    = {1'b0, m0.awid};
    aw_addr   = m0.awaddr;
    s.awlen   = m0.awlen;
    s.awsize  = m0.awsize;
    s.awburst = m0.awburst;
    s.awlock  = m0.awlock;
    s.awcache = m0.awcache;
    s.awprot  = m0.awprot;
    s.awqos   = m0.awqos;
    if (aw_gnt) begin
      s.awid    = {1'b1, m1.awid};
      aw_addr   = m1.awaddr;
      s.awlen   = m1.awlen;
      s.awsize  = m1.awsize;
      s.awburst = m1.awburst;
      s.awlock  = m1.awlock;
      s.awcache = m1.awcache;
      s.awprot  = m1.awprot;
      s.awqos   = m1.awqos;
    end
    s.awaddr = aw_addr;
  end

  // Hold the grant while the slave stalls a presented request.
  always_comb begin
    aw_st_d   = aw_st_q;
    aw_hold_d = aw_hold_q;
    aw_last_d = aw_last_q;
    if (aw_valid) begin
      if (s.awready) begin
        aw_st_d   = StFree;
        aw_last_d = aw_gnt;
      end else begin
        aw_st_d   = StHold;
        aw_hold_d = aw_gnt;
      end
    end
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      aw_st_q   <= StFree;
      aw_hold_q <= 1'b0;
      aw_last_q <= 1'b1;
    end else begin
      aw_st_q   <= aw_st_d;
      aw_hold_q <= aw_hold_d;
      aw_last_q <= aw_last_d;
    end
  end

  // ---------------------------------------------------------------------------
  // AR arbitration
  // ---------------------------------------------------------------------------
  arb_state_e ar_st_q, ar_st_d;
  logic ar_hold_q, ar_hold_d;
  logic ar_last_q, ar_last_d;
  logic ar_gnt, ar_req, ar_valid;
  logic [ADDR_WIDTH-1:0] ar_addr;

  always_comb begin
    ar_gnt = 1'b0;
    if (ar_st_q == StHold) begin
      ar_gnt = ar_hold_q;
    end else if (m0.arvalid && m1.arvalid) begin
      ar_gnt = ~ar_last_q;
    end else begin
      ar_gnt = m1.arvalid;
    end
  end

  always_comb begin
    ar_req     = ar_gnt ? m1.arvalid : m0.arvalid;
    ar_valid   = ARESETn && ar_req;
    s.arvalid  = ar_valid;
    m0.arready = ARESETn && !ar_gnt && s.arready;
    m1.arready = ARESETn && ar_gnt && s.arready;
  end

  always_comb begin
    s.arid    = {1'b0, m0.arid};
    ar_addr   = m0.araddr;
    s.arlen   = m0.arlen;
    s.arsize  = m0.arsize;
    s.arburst = m0.arburst;
    s.arlock  = m0.arlock;
    s.arcache = m0.arcache;
    s.arprot  = m0.arprot;
    s.arqos   = m0.arqos;
    if (ar_gnt) begin
      s.arid    = {1'b1, m1.arid};
      ar_addr   = m1.araddr;
      s.arlen   = m1.arlen;
      s.arsize  = m1.arsize;
      s.arburst = m1.arburst;
      s.arlock  = m1.arlock;
      s.arcache = m1.arcache;
      s.arprot  = m1.arprot;
      s.arqos   = m1.arqos;
    end
    s.araddr = ar_addr;
  end

  always_comb begin
    ar_st_d   = ar_st_q;
    ar_hold_d = ar_hold_q;
    ar_last_d = ar_last_q;
    if (ar_valid) begin
      if (s.arready) begin
        ar_st_d   = StFree;
        ar_last_d = ar_gnt;
      end else begin
        ar_st_d   = StHold;
        ar_hold_d = ar_gnt;
      end
    end
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      ar_st_q   <= StFree;
      ar_hold_q <= 1'b0;
      ar_last_q <= 1'b1;
    end else begin
      ar_st_q   <= ar_st_d;
      ar_hold_q <= ar_hold_d;
      ar_last_q <= ar_last_d;
    end
  end

  // ---------------------------------------------------------------------------
  // W steering: queue of granted AW sources, popped on each WLAST beat
  // ---------------------------------------------------------------------------
  logic w_valid, w_last;
  logic [DATA_WIDTH-1:0] w_data;
  logic [StrbWidth-1:0] w_strb;

  always_comb begin
    wq_empty = (wq_wptr_q == wq_rptr_q);
    wq_full  = (wq_wptr_q[PtrW] != wq_rptr_q[PtrW]) &&
               (wq_wptr_q[PtrW-1:0] == wq_rptr_q[PtrW-1:0]);
    wq_head  = wq_mem_q[wq_rptr_q[PtrW-1:0]];
  end

  always_comb begin
    w_data  = wq_head ? m1.wdata : m0.wdata;
    w_strb  = wq_head ? m1.wstrb : m0.wstrb;
    w_last  = wq_head ? m1.wlast : m0.wlast;
    w_valid = ARESETn && !wq_empty && (wq_head ? m1.wvalid : m0.wvalid);
    wq_pop  = w_valid && s.wready && w_last;
    s.wdata    = w_data;
    s.wstrb    = w_strb;
    s.wlast    = w_last;
    s.wvalid   = w_valid;
    m0.wready  = ARESETn && !wq_empty && !wq_head && s.wready;
    m1.wready  = ARESETn && !wq_empty && wq_head && s.wready;
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      wq_mem_q  <= '0;
      wq_wptr_q <= '0;
      wq_rptr_q <= '0;
    end else begin
      if (aw_hs) begin
        wq_mem_q[wq_wptr_q[PtrW-1:0]] <= aw_gnt;
        wq_wptr_q <= wq_wptr_q + PtrOne;
      end
      if (wq_pop) begin
        wq_rptr_q <= wq_rptr_q + PtrOne;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // B / R return routing on the ID source bit, unbuffered
  // ---------------------------------------------------------------------------
  logic b_idx, r_idx;

  always_comb begin
    b_idx     = s.bid[ID_WIDTH];
    m0.bid    = s.bid[ID_WIDTH-1:0];
    m1.bid    = s.bid[ID_WIDTH-1:0];
    m0.bresp  = s.bresp;
    m1.bresp  = s.bresp;
    m0.bvalid = ARESETn && s.bvalid && !b_idx;
    m1.bvalid = ARESETn && s.bvalid && b_idx;
    s.bready  = ARESETn && (b_idx ? m1.bready : m0.bready);
  end

  always_comb begin
    r_idx     = s.rid[ID_WIDTH];
    m0.rid    = s.rid[ID_WIDTH-1:0];
    m1.rid    = s.rid[ID_WIDTH-1:0];
    m0.rdata  = s.rdata;
    m1.rdata  = s.rdata;
    m0.rresp  = s.rresp;
    m1.rresp  = s.rresp;
    m0.rlast  = s.rlast;
    m1.rlast  = s.rlast;
    m0.rvalid = ARESETn && s.rvalid && !r_idx;
    m1.rvalid = ARESETn && s.rvalid && r_idx;
    s.rready  = ARESETn && (r_idx ? m1.rready : m0.rready);
  end

endmodule

// File: tb/tb_axi4_arbiter_2x1.sv
// Bench for axi4_arbiter_2x1: directed stimulus pushes expected transfers into queues,
// a negedge monitor pops and compares them as handshakes occur.
module tb_axi4_arbiter_2x1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  axi4_if #(.ADDR_WIDTH(32), .DATA_WIDTH(64), .ID_WIDTH(4)) m0_if ();
  axi4_if #(.ADDR_WIDTH(32), .DATA_WIDTH(64), .ID_WIDTH(4)) m1_if ();
  axi4_if #(.ADDR_WIDTH(32), .DATA_WIDTH(64), .ID_WIDTH(5)) s_if ();

  axi4_arbiter_2x1 #(
    .ADDR_WIDTH(32),
    .DATA_WIDTH(64),
    .ID_WIDTH(4),
    .WQ_DEPTH(4)
  ) dut (
    .ACLK(clk),
    .ARESETn(rst_n),
    .m0(m0_if),
    .m1(m1_if),
    .s(s_if)
  );

  typedef struct packed {logic [4:0] id; logic [31:0] addr;} ax_t;
  typedef struct packed {logic [63:0] data; logic last;} w_t;
  typedef struct packed {logic idx; logic [3:0] id; logic [63:0] data; logic [1:0] resp;} rsp_t;

  ax_t  ar_q[$];
  ax_t  aw_q[$];
  w_t   w_q[$];
  rsp_t r_q[$];
  rsp_t b_q[$];

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic unexpected(input string name);
    checks++;
    errors++;
    $display("FAIL %s: handshake with no expected entry", name);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_ax(input bit is_aw, input bit m, input logic [3:0] id,
                         input logic [31:0] addr);
    ax_t e;
    e.id   = {m, id};
    e.addr = addr;
    if (is_aw) aw_q.push_back(e);
    else ar_q.push_back(e);
  endtask

  task automatic push_w(input logic [63:0] data, input logic last);
    w_t e;
    e.data = data;
    e.last = last;
    w_q.push_back(e);
  endtask

  task automatic push_rsp(input bit is_b, input bit m, input logic [3:0] id,
                          input logic [63:0] data, input logic [1:0] resp);
    rsp_t e;
    e.idx  = m;
    e.id   = id;
    e.data = data;
    e.resp = resp;
    if (is_b) b_q.push_back(e);
    else r_q.push_back(e);
  endtask

  task automatic send_aw(input bit m, input logic [3:0] id, input logic [31:0] addr,
                         input logic [7:0] len);
    bit done;
    done = 1'b0;
    if (m) begin
      m1_if.awvalid = 1'b1; m1_if.awid = id; m1_if.awaddr = addr; m1_if.awlen = len;
    end else begin
      m0_if.awvalid = 1'b1; m0_if.awid = id; m0_if.awaddr = addr; m0_if.awlen = len;
    end
    push_ax(1'b1, m, id, addr);
    for (int t = 0; t < 100 && !done; t++) begin
      @(posedge clk);
      done = m ? m1_if.awready : m0_if.awready;
    end
    #1;
    if (m) m1_if.awvalid = 1'b0;
    else m0_if.awvalid = 1'b0;
    if (!done) unexpected("aw_timeout");
  endtask

  task automatic send_w(input bit m, input logic [63:0] base, input int beats);
    bit done;
    for (int b = 0; b < beats; b++) begin
      done = 1'b0;
      if (m) begin
        m1_if.wvalid = 1'b1; m1_if.wdata = base + 64'(b); m1_if.wlast = (b == beats - 1);
      end else begin
        m0_if.wvalid = 1'b1; m0_if.wdata = base + 64'(b); m0_if.wlast = (b == beats - 1);
      end
      for (int t = 0; t < 200 && !done; t++) begin
        @(posedge clk);
        done = m ? m1_if.wready : m0_if.wready;
      end
      #1;
      if (!done) unexpected("w_timeout");
    end
    if (m) m1_if.wvalid = 1'b0;
    else m0_if.wvalid = 1'b0;
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    if (rst_n) begin
      if (s_if.arvalid && s_if.arready) begin
        if (ar_q.size() == 0) unexpected("ar");
        else begin
          ax_t e;
          e = ar_q.pop_front();
          check("ar_id", 64'(s_if.arid), 64'(e.id));
          check("ar_addr", 64'(s_if.araddr), 64'(e.addr));
        end
      end
      if (s_if.awvalid && s_if.awready) begin
        if (aw_q.size() == 0) unexpected("aw");
        else begin
          ax_t e;
          e = aw_q.pop_front();
          check("aw_id", 64'(s_if.awid), 64'(e.id));
          check("aw_addr", 64'(s_if.awaddr), 64'(e.addr));
        end
      end
      if (s_if.wvalid && s_if.wready) begin
        if (w_q.size() == 0) unexpected("w");
        else begin
          w_t e;
          e = w_q.pop_front();
          check("w_data", s_if.wdata, e.data);
          check("w_last", 64'(s_if.wlast), 64'(e.last));
        end
      end
      if (s_if.rvalid && s_if.rready) begin
        if (r_q.size() == 0) unexpected("r");
        else begin
          rsp_t e;
          e = r_q.pop_front();
          check("r_m0_valid", 64'(m0_if.rvalid), 64'(!e.idx));
          check("r_m1_valid", 64'(m1_if.rvalid), 64'(e.idx));
          check("r_id", 64'(e.idx ? m1_if.rid : m0_if.rid), 64'(e.id));
          check("r_data", e.idx ? m1_if.rdata : m0_if.rdata, e.data);
          check("r_last", 64'(e.idx ? m1_if.rlast : m0_if.rlast), 64'd1);
        end
      end
      if (s_if.bvalid && s_if.bready) begin
        if (b_q.size() == 0) unexpected("b");
        else begin
          rsp_t e;
          e = b_q.pop_front();
          check("b_m0_valid", 64'(m0_if.bvalid), 64'(!e.idx));
          check("b_m1_valid", 64'(m1_if.bvalid), 64'(e.idx));
          check("b_id", 64'(e.idx ? m1_if.bid : m0_if.bid), 64'(e.id));
          check("b_resp", 64'(e.idx ? m1_if.bresp : m0_if.bresp), 64'(e.resp));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    {m0_if.awid, m0_if.awaddr, m0_if.awlen, m0_if.awsize, m0_if.awburst} = '0;
    {m0_if.awlock, m0_if.awcache, m0_if.awprot, m0_if.awqos} = '0;
    {m0_if.arid, m0_if.araddr, m0_if.arlen, m0_if.arsize, m0_if.arburst} = '0;
    {m0_if.arlock, m0_if.arcache, m0_if.arprot, m0_if.arqos} = '0;
    {m0_if.wdata, m0_if.wlast, m0_if.bready, m0_if.rready} = '0;
    m0_if.wstrb = '1;
    {m1_if.awid, m1_if.awaddr, m1_if.awlen, m1_if.awsize, m1_if.awburst} = '0;
    {m1_if.awlock, m1_if.awcache, m1_if.awprot, m1_if.awqos} = '0;
    {m1_if.arid, m1_if.araddr, m1_if.arlen, m1_if.arsize, m1_if.arburst} = '0;
    {m1_if.arlock, m1_if.arcache, m1_if.arprot, m1_if.arqos} = '0;
    {m1_if.wdata, m1_if.wlast, m1_if.bready, m1_if.rready} = '0;
    m1_if.wstrb = '1;
    {s_if.bid, s_if.bresp, s_if.rid, s_if.rdata, s_if.rresp, s_if.rlast} = '0;

    // Reset held with every valid and ready asserted
    m0_if.awvalid = 1'b1; m1_if.awvalid = 1'b1;
    m0_if.arvalid = 1'b1; m1_if.arvalid = 1'b1;
    m0_if.wvalid  = 1'b1; m1_if.wvalid  = 1'b1;
    m0_if.bready  = 1'b1; m1_if.bready  = 1'b1;
    m0_if.rready  = 1'b1; m1_if.rready  = 1'b1;
    s_if.awready = 1'b1; s_if.arready = 1'b1; s_if.wready = 1'b1;
    s_if.bvalid  = 1'b1; s_if.rvalid  = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_s_awvalid", 64'(s_if.awvalid), 64'd0);
    check("rst_s_arvalid", 64'(s_if.arvalid), 64'd0);
    check("rst_s_wvalid", 64'(s_if.wvalid), 64'd0);
    check("rst_m_awready", 64'({m0_if.awready, m1_if.awready}), 64'd0);
    check("rst_m_arready", 64'({m0_if.arready, m1_if.arready}), 64'd0);
    check("rst_m_wready", 64'({m0_if.wready, m1_if.wready}), 64'd0);
    check("rst_m_bvalid", 64'({m0_if.bvalid, m1_if.bvalid}), 64'd0);
    check("rst_m_rvalid", 64'({m0_if.rvalid, m1_if.rvalid}), 64'd0);
    tick();
    m0_if.awvalid = 1'b0; m1_if.awvalid = 1'b0;
    m0_if.wvalid  = 1'b0; m1_if.wvalid  = 1'b0;
    s_if.bvalid = 1'b0; s_if.rvalid = 1'b0;
    m0_if.bready = 1'b0; m1_if.bready = 1'b0;
    m0_if.rready = 1'b0; m1_if.rready = 1'b0;
    m0_if.arid = 4'h3; m1_if.arid = 4'h9;
    rst_n = 1'b1;

    // Both AR requesters every cycle: m0 wins the first tie, then alternation
    for (int k = 0; k < 6; k++) begin
      m0_if.araddr = 32'h1000 + 32'(k);
      m1_if.araddr = 32'h2000 + 32'(k);
      if (k % 2 == 0) push_ax(1'b0, 1'b0, 4'h3, 32'h1000 + 32'(k));
      else push_ax(1'b0, 1'b1, 4'h9, 32'h2000 + 32'(k));
      if (k == 0) begin
        @(negedge clk);
        check("first_tie_arid", 64'(s_if.arid), 64'h03);
      end
      tick();
    end
    m0_if.arvalid = 1'b0; m1_if.arvalid = 1'b0;
    tick();

    // AR grant held on m1 while slave stalls, even with m0 requesting
    s_if.arready = 1'b0;
    m1_if.arvalid = 1'b1; m1_if.arid = 4'h7; m1_if.araddr = 32'h3000;
    m0_if.arid = 4'h4; m0_if.araddr = 32'h4000;
    for (int k = 0; k < 3; k++) begin
      if (k == 1) m0_if.arvalid = 1'b1;
      @(negedge clk);
      check("ar_lock_id", 64'(s_if.arid), 64'h17);
      check("ar_lock_m0_ready", 64'(m0_if.arready), 64'd0);
      tick();
    end
    s_if.arready = 1'b1;
    push_ax(1'b0, 1'b1, 4'h7, 32'h3000);
    tick();
    m1_if.arvalid = 1'b0;
    push_ax(1'b0, 1'b0, 4'h4, 32'h4000);
    tick();
    m0_if.arvalid = 1'b0;
    tick();

    // W order follows AW grants; m1 data presented first must wait
    for (int b = 0; b < 4; b++) push_w(64'hA000 + 64'(b), b == 3);
    push_w(64'hB000, 1'b1);
    fork
      begin
        send_aw(1'b0, 4'h2, 32'h5000, 8'd3);
        @(negedge clk);
        check("w_m1_stall", 64'(m1_if.wready), 64'd0);
        check("w_m0_head_ready", 64'(m0_if.wready), 64'd1);
        send_aw(1'b1, 4'h6, 32'h6000, 8'd0);
      end
      send_w(1'b1, 64'hB000, 1);
      send_w(1'b0, 64'hA000, 4);
    join
    tick();

    // W queue full gates AW until one WLAST drains an entry
    s_if.wready = 1'b0;
    for (int i = 0; i < 4; i++) send_aw(1'b0, 4'h1, 32'h7000 + 32'(i), 8'd0);
    for (int i = 0; i < 5; i++) push_w(64'hC000 + 64'(i), 1'b1);
    fork
      send_aw(1'b0, 4'h5, 32'h7004, 8'd0);
      begin
        repeat (3) begin
          @(negedge clk);
          check("wq_full_awvalid", 64'(s_if.awvalid), 64'd0);
          check("wq_full_awready", 64'(m0_if.awready), 64'd0);
        end
        tick();
        s_if.wready = 1'b1;
        for (int i = 0; i < 5; i++) send_w(1'b0, 64'hC000 + 64'(i), 1);
      end
    join
    tick();

    // R/B routing by ID source bit
    s_if.rvalid = 1'b1; s_if.rid = 5'h1A; s_if.rdata = 64'hDEAD_BEEF_0123_4567;
    s_if.rresp = 2'b00; s_if.rlast = 1'b1;
    m1_if.rready = 1'b1; m0_if.rready = 1'b0;
    push_rsp(1'b0, 1'b1, 4'hA, 64'hDEAD_BEEF_0123_4567, 2'b00);
    tick();
    s_if.rid = 5'h05; s_if.rdata = 64'h1111_2222_3333_4444;
    m0_if.rready = 1'b1; m1_if.rready = 1'b0;
    push_rsp(1'b0, 1'b0, 4'h5, 64'h1111_2222_3333_4444, 2'b00);
    tick();
    s_if.rvalid = 1'b0;
    s_if.bvalid = 1'b1; s_if.bid = 5'h03; s_if.bresp = 2'b10;
    m0_if.bready = 1'b0; m1_if.bready = 1'b1;
    @(negedge clk);
    check("b_ready_route", 64'(s_if.bready), 64'd0);
    check("b_m1_quiet", 64'(m1_if.bvalid), 64'd0);
    tick();
    m0_if.bready = 1'b1;
    push_rsp(1'b1, 1'b0, 4'h3, 64'd0, 2'b10);
    tick();
    s_if.bvalid = 1'b0;
    repeat (3) tick();

    check("ar_q_drained", 64'(ar_q.size()), 64'd0);
    check("aw_q_drained", 64'(aw_q.size()), 64'd0);
    check("w_q_drained", 64'(w_q.size()), 64'd0);
    check("r_q_drained", 64'(r_q.size()), 64'd0);
    check("b_q_drained", 64'(b_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
